// File: rtl/instruction_fetch_queue.sv
// Fetch-to-decode instruction queue: pushed words show on out_* the cycle after the push; in_ready drops when fewer than FETCH_WIDTH entries are free.
// Define BRANCH_PREDECODE_EN to store a 2-bit branch class per entry; otherwise out_branch_class is tied to zero.
module instruction_fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   in_count,
  input  logic [31:0]                        in_address,
  input  logic [FETCH_WIDTH*32-1:0]          in_instructions,
  output logic                               in_ready,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*32-1:0]          out_instructions,
  output logic [ISSUE_WIDTH*32-1:0]          out_address,
  output logic [ISSUE_WIDTH*2-1:0]           out_branch_class,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_taken,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(FETCH_WIDTH+1);
  localparam int OW = $clog2(DEPTH+1);

  logic [31:0]   r_mem  [DEPTH];
  logic [31:0]   r_addr [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;

  logic          w_push;
  logic [OW-1:0] w_push_n;
  logic [OW-1:0] w_nvalid;
  logic [OW-1:0] w_pop_n;

  assign in_ready  = (r_occ <= OW'(DEPTH - FETCH_WIDTH));
  assign occupancy = r_occ;

  always_comb begin
    w_push   = rst && !flush && in_valid && in_ready && (in_count != '0);
    w_push_n = '0;
    if (w_push)
      w_push_n = (in_count > CW'(FETCH_WIDTH)) ? OW'(FETCH_WIDTH) : OW'(in_count);
    w_nvalid = (r_occ > OW'(ISSUE_WIDTH)) ? OW'(ISSUE_WIDTH) : r_occ;
    // Consumers may over-ask; only lanes that are actually valid can leave.
    w_pop_n  = (OW'(out_taken) > w_nvalid) ? w_nvalid : OW'(out_taken);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_tail <= r_tail + PW'(w_push_n);
      r_head <= r_head + PW'(w_pop_n);
      r_occ  <= r_occ + w_push_n - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k < int'(w_push_n)) begin
        r_mem[r_tail + PW'(k)]  <= in_instructions[32*k +: 32];
        r_addr[r_tail + PW'(k)] <= in_address + 32'(4*k);
      end
    end
  end

`ifdef BRANCH_PREDECODE_EN
  logic [1:0] r_cls [DEPTH];

  // Bit numbering is big-endian: opcode is insn bits 0:5, XO is bits 21:30.
  function automatic logic [1:0] f_class(input logic [31:0] insn);
    logic [5:0] w_op;
    logic [9:0] w_xo;
    w_op = insn[31:26];
    w_xo = insn[10:1];
    if (w_op == 6'd18)      f_class = 2'b01;
    else if (w_op == 6'd16) f_class = 2'b10;
    else if (w_op == 6'd19 && (w_xo == 10'd16 || w_xo == 10'd528)) f_class = 2'b11;
    else                    f_class = 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k < int'(w_push_n))
        r_cls[r_tail + PW'(k)] <= f_class(in_instructions[32*k +: 32]);
    end
  end
`endif

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
    logic [PW-1:0] w_idx;
    assign w_idx                       = r_head + PW'(g);
    assign out_valid[g]                = (r_occ > OW'(g));
    assign out_instructions[32*g +: 32] = r_mem[w_idx];
    assign out_address[32*g +: 32]      = r_addr[w_idx];
`ifdef BRANCH_PREDECODE_EN
    assign out_branch_class[2*g +: 2]   = r_cls[w_idx];
`else
    assign out_branch_class[2*g +: 2]   = 2'b00;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_count;
  logic [31:0] in_address;
  logic [63:0] in_instructions;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_instructions;
  logic [63:0] out_address;
  logic [3:0]  out_branch_class;
  logic [1:0]  out_taken;
  logic [3:0]  occupancy;

  instruction_fetch_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_count(in_count), .in_address(in_address),
    .in_instructions(in_instructions), .in_ready(in_ready),
    .out_valid(out_valid), .out_instructions(out_instructions),
    .out_address(out_address), .out_branch_class(out_branch_class),
    .out_taken(out_taken), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic [1:0]  cls;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [1:0] e_cls(input logic [1:0] c);
`ifdef BRANCH_PREDECODE_EN
    return c;
`else
    return 2'b00;
`endif
  endfunction

  // One clock: check visible lanes against the scoreboard, drive, clock, update model, check counters.
  task automatic cyc(input logic v, input logic [1:0] cnt, input logic [31:0] a,
                     input logic [31:0] w0, input logic [1:0] c0,
                     input logic [31:0] w1, input logic [1:0] c1,
                     input logic [1:0] tk, input logic fl);
    bit acc;
    int pn;
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", 32'(out_valid[k]), 32'(q.size() > k));
      if (q.size() > k) begin
        chk("lane_insn", out_instructions[32*k +: 32], q[k].insn);
        chk("lane_addr", out_address[32*k +: 32], q[k].addr);
        chk("lane_class", 32'(out_branch_class[2*k +: 2]), 32'(q[k].cls));
      end
    end
    in_valid        = v;
    in_count        = cnt;
    in_address      = a;
    in_instructions = {w1, w0};
    out_taken       = tk;
    flush           = fl;
    acc = v && (q.size() <= 6) && (cnt != 2'd0) && !fl;
    pn  = int'(tk);
    if (pn > q.size()) pn = q.size();
    if (pn > 2) pn = 2;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      for (int k = 0; k < pn; k++) void'(q.pop_front());
      if (acc) begin
        e.insn = w0; e.addr = a; e.cls = e_cls(c0);
        q.push_back(e);
        if (cnt == 2'd2) begin
          e.insn = w1; e.addr = a + 32'd4; e.cls = e_cls(c1);
          q.push_back(e);
        end
      end
    end
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() <= 6));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_count = 2'd2;
    in_address = 32'h0; in_instructions = 64'h0; out_taken = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic group with b / bc predecode, then drain.
    cyc(1, 2, 32'h100, 32'h4829C034, 2'b01, 32'h41095BBC, 2'b10, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 2, 0);

    // Mixed group sizes; bcctr/bclr classes; partial pop.
    cyc(1, 2, 32'h200, 32'h4D890420, 2'b11, 32'h4D890020, 2'b11, 0, 0);
    cyc(1, 1, 32'h208, 32'h7C000000, 2'b00, 32'h0, 2'b00, 0, 0);
    chk("occ_three", 32'(occupancy), 32'd3);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 1, 0);
    chk("lane0_after_pop", out_instructions[31:0], 32'h4D890020);
    cyc(1, 0, 32'h900, 32'h48000000, 2'b01, 32'h0, 2'b00, 2, 0);

    // Fill to full, rejected push, pop and wrap.
    for (int i = 0; i < 4; i++)
      cyc(1, 2, 32'h300 + 32'(8*i), 32'h60000000 + 32'(2*i), 2'b00,
          32'h40000001 + 32'(2*i), 2'b10, 0, 0);
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    cyc(1, 2, 32'hBAD0, 32'h48000BAD, 2'b01, 32'h48000BAD, 2'b01, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 2, 0);
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    cyc(1, 2, 32'h400, 32'h4E800020, 2'b11, 32'h4E800420, 2'b11, 2, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 2, 0);

    // Simultaneous push/pop at 4, then clamped over-pop.
    cyc(1, 2, 32'h500, 32'h4C000020, 2'b11, 32'h38600001, 2'b00, 0, 0);
    cyc(1, 2, 32'h508, 32'h4BFFFFF0, 2'b01, 32'h41820010, 2'b10, 0, 0);
    cyc(1, 2, 32'h510, 32'h7C0802A6, 2'b00, 32'h4C000420, 2'b11, 2, 0);
    chk("pushpop_occ", 32'(occupancy), 32'd4);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 2, 0);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 1, 0);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 2, 0);
    chk("clamp_occ", 32'(occupancy), 32'd0);

    // Flush beats same-cycle push and pop at occupancy 5.
    cyc(1, 2, 32'h600, 32'h60000010, 2'b00, 32'h60000011, 2'b00, 0, 0);
    cyc(1, 2, 32'h608, 32'h60000012, 2'b00, 32'h60000013, 2'b00, 0, 0);
    cyc(1, 1, 32'h610, 32'h60000014, 2'b00, 32'h0, 2'b00, 0, 0);
    cyc(1, 2, 32'h700, 32'h48001234, 2'b01, 32'h40001234, 2'b10, 2, 1);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1, 1, 32'h800, 32'h48000008, 2'b01, 32'h0, 2'b00, 0, 0);
    chk("post_flush_lane0", out_instructions[31:0], 32'h48000008);
    cyc(0, 0, 32'h0, 32'h0, 2'b00, 32'h0, 2'b00, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
